// File: rtl/rv32_pkg.sv
// rv32_pkg: shared register-file constants (address width, XLEN, register count, x0 index)
package rv32_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: register-file bus; master drives wr_ena/wr_addr/wr_data/rd_addr0/rd_addr1, slave drives rd_data0/rd_data1
interface register_file_if import rv32_pkg::*; #(parameter int N = XLEN);
  logic wr_ena;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic [REG_ADDR_W-1:0] rd_addr0;
  logic [REG_ADDR_W-1:0] rd_addr1;
  logic [N-1:0] rd_data0;
  logic [N-1:0] rd_data1;
  modport master (output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1, input rd_data0, rd_data1);
  modport slave (input wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1, output rd_data0, rd_data1);
endinterface

// File: rtl/mux32.sv
// mux32: 32:1 N-bit selector; ports d (32 inputs), sel (5-bit), y
module mux32 #(parameter int N = 32) (
  input  logic [N-1:0] d [32],
  input  logic [4:0]   sel,
  output logic [N-1:0] y
);
  assign y = d[sel];
endmodule

// File: rtl/register_en.sv
// register_en: N-bit flop, sync active-high reset to 0, load enable; ports clk, rst, en, d, q
module register_en #(parameter int N = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/register_file.sv
// register_file: 32 x N regfile, x0 reads 0, one sync write port, two combinational read ports; ports clk, rst (sync active-high), bus (slave)
module register_file import rv32_pkg::*; #(parameter int N = XLEN) (
  input logic clk,
  input logic rst,
  register_file_if.slave bus
);
  logic [N-1:0] regs [NUM_REGS];
  assign regs[X0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    register_en #(.N(N)) u_reg (
      .clk(clk),
      .rst(rst),
      .en(bus.wr_ena && bus.wr_addr == REG_ADDR_W'(i)),
      .d(bus.wr_data),
      .q(regs[i])
    );
  end
  mux32 #(.N(N)) u_rd0 (.d(regs), .sel(bus.rd_addr0), .y(bus.rd_data0));
  mux32 #(.N(N)) u_rd1 (.d(regs), .sel(bus.rd_addr1), .y(bus.rd_data1));
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table-driven and random self-checking bench for register_file
module tb_register_file;
  import rv32_pkg::*;
  typedef struct {
    logic rst;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  register_file_if #(.N(XLEN)) bus();
  register_file #(.N(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [63:0] sb [$];
  logic [31:0] mdl [32];
  vec_t tbl [12];

  function automatic vec_t mk(logic r, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] ra0, logic [4:0] ra1, logic [31:0] e0, logic [31:0] e1);
    vec_t v;
    v.rst = r; v.we = we; v.wa = wa; v.wd = wd;
    v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req, bit stop);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
      if (stop) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "random traffic diverged from reference model");
      end
    end
  endtask

  // Drive one cycle: reads are checked combinationally before the edge, model updated at the edge.
  task automatic step(vec_t v, string name, bit stop);
    logic [63:0] e;
    rst = v.rst;
    bus.wr_ena = v.we;
    bus.wr_addr = v.wa;
    bus.wr_data = v.wd;
    bus.rd_addr0 = v.ra0;
    bus.rd_addr1 = v.ra1;
    sb.push_back({v.e0, v.e1});
    #1;
    e = sb.pop_front();
    check({name, "/rd0"}, bus.rd_data0, e[63:32], stop);
    check({name, "/rd1"}, bus.rd_data1, e[31:0], stop);
    @(posedge clk);
    if (v.rst) for (int k = 0; k < 32; k++) mdl[k] = '0;
    else if (v.we && v.wa != 5'd0) mdl[v.wa] = v.wd;
    @(negedge clk);
  endtask

  initial begin
    mdl[0] = '0;
    tbl[0]  = mk(1, 0, 0, 0,            0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 5, 32'hDEADBEEF, 5, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0,            5, 5, 32'hDEADBEEF, 32'hDEADBEEF);
    tbl[3]  = mk(0, 0, 0, 0,            5, 5, 0, 0);
    tbl[4]  = mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,            0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 7, 32'h11111111, 7, 0, 0, 0);
    tbl[7]  = mk(0, 1, 7, 32'h22222222, 7, 7, 32'h11111111, 32'h11111111);
    tbl[8]  = mk(0, 1, 7, 32'h33333333, 7, 0, 32'h22222222, 0);
    tbl[9]  = mk(0, 1, 3, 32'hABCD0123, 7, 3, 32'h33333333, 0);
    tbl[10] = mk(1, 1, 3, 32'h55555555, 3, 7, 32'hABCD0123, 32'h33333333);
    tbl[11] = mk(0, 0, 0, 0,            3, 7, 0, 0);
    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i), 1'b0);
    for (int a = 0; a < 32; a++)
      step(mk(0, 0, 0, 0, 5'(a), 5'(31 - a), 0, 0), $sformatf("reset_sweep%0d", a), 1'b0);
    for (int i = 1; i < 32; i++)
      step(mk(0, 1, 5'(i), 32'h10000000 + i, 5'(i), 0, 0, 0), $sformatf("write_all%0d", i), 1'b0);
    for (int a = 0; a < 32; a++)
      step(mk(0, 0, 0, 0, 5'(a), 5'(31 - a),
              a == 0 ? 32'h0 : 32'h10000000 + a,
              a == 31 ? 32'h0 : 32'h10000000 + (31 - a)),
           $sformatf("read_all%0d", a), 1'b0);
    for (int n = 0; n < 1000; n++) begin
      vec_t v;
      v = mk($urandom_range(0, 49) == 0, 1'($urandom), 5'($urandom), $urandom,
             5'($urandom), 5'($urandom), 0, 0);
      v.e0 = mdl[v.ra0];
      v.e1 = mdl[v.ra1];
      step(v, $sformatf("rand%0d", n), 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
